// File: rtl/credit_rr_tx.sv
// Credit-based transmitter: round-robin over QUEUE_COUNT queues onto one link, with a
// registered output beat and absolute cumulative credit returns from the receiver.
module credit_rr_tx #(
   parameter int QUEUE_COUNT = 2,
   parameter int DATA_WIDTH  = 8,
   parameter int DEPTH       = 4,
   parameter int CNT_WIDTH   = $clog2(DEPTH) + 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [QUEUE_COUNT-1:0]            in_valid,
   output logic [QUEUE_COUNT-1:0]            in_ready,
   input  logic [QUEUE_COUNT*DATA_WIDTH-1:0] in_payload,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [DATA_WIDTH-1:0]             out_payload,
   output logic [$clog2(QUEUE_COUNT)-1:0]    out_src,
   input  logic                              credit_valid,
   input  logic [QUEUE_COUNT*CNT_WIDTH-1:0]  credit_freed,
   output logic                              credit_err
);

   localparam int SRC_WIDTH = $clog2(QUEUE_COUNT);
   localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);

   logic [CNT_WIDTH-1:0]  sent_q [QUEUE_COUNT];
   logic [CNT_WIDTH-1:0]  sent_d [QUEUE_COUNT];
   logic [CNT_WIDTH-1:0]  freed_q [QUEUE_COUNT];
   logic [CNT_WIDTH-1:0]  freed_d [QUEUE_COUNT];
   logic [CNT_WIDTH-1:0]  inflight [QUEUE_COUNT];
   logic [QUEUE_COUNT-1:0] eligible;
   logic [SRC_WIDTH-1:0]  rr_q, rr_d;
   logic [SRC_WIDTH-1:0]  grant;
   logic                  grant_vld;
   logic                  slot_free;
   logic                  take;
   int                    idx;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_payload_q, out_payload_d;
   logic [SRC_WIDTH-1:0]  out_src_q, out_src_d;
   logic                  err_q, err_d;
   logic [CNT_WIDTH-1:0]  upd, delta;

   // Arbitration sees only registered credit state, so in_ready never follows credit inputs.
   always_comb begin
      slot_free = !out_valid_q || out_ready;
      grant     = '0;
      grant_vld = 1'b0;
      idx       = 0;
      for (int i = 0; i < QUEUE_COUNT; i++) begin
         inflight[i] = sent_q[i] - freed_q[i];
         eligible[i] = in_valid[i] && (inflight[i] < DEPTH_C);
      end
      // Walk from farthest to nearest so the queue closest to rr_q wins.
      for (int k = QUEUE_COUNT - 1; k >= 0; k--) begin
         idx = (int'(rr_q) + k) % QUEUE_COUNT;
         if (eligible[idx]) begin
            grant     = SRC_WIDTH'(idx);
            grant_vld = 1'b1;
         end
      end
      in_ready = '0;
      if (grant_vld && slot_free && !rst) in_ready[grant] = 1'b1;
      take = |(in_ready & in_valid);
   end

   always_comb begin
      out_valid_d   = out_valid_q && !out_ready;
      out_payload_d = out_payload_q;
      out_src_d     = out_src_q;
      rr_d          = rr_q;
      err_d         = err_q;
      upd           = '0;
      delta         = '0;
      for (int i = 0; i < QUEUE_COUNT; i++) begin
         sent_d[i]  = sent_q[i];
         freed_d[i] = freed_q[i];
      end
      if (take) begin
         out_valid_d    = 1'b1;
         out_payload_d  = in_payload[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
         out_src_d      = grant;
         rr_d           = SRC_WIDTH'((int'(grant) + 1) % QUEUE_COUNT);
         sent_d[grant]  = sent_q[grant] + 1'b1;
      end
      // An update claiming more drained entries than are outstanding is stale or corrupt.
      if (credit_valid) begin
         for (int i = 0; i < QUEUE_COUNT; i++) begin
            upd   = credit_freed[i*CNT_WIDTH +: CNT_WIDTH];
            delta = upd - freed_q[i];
            if (delta <= inflight[i]) freed_d[i] = upd;
            else                      err_d      = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < QUEUE_COUNT; i++) begin
            sent_q[i]  <= '0;
            freed_q[i] <= '0;
         end
         rr_q          <= '0;
         out_valid_q   <= 1'b0;
         out_payload_q <= '0;
         out_src_q     <= '0;
         err_q         <= 1'b0;
      end else begin
         for (int i = 0; i < QUEUE_COUNT; i++) begin
            sent_q[i]  <= sent_d[i];
            freed_q[i] <= freed_d[i];
         end
         rr_q          <= rr_d;
         out_valid_q   <= out_valid_d;
         out_payload_q <= out_payload_d;
         out_src_q     <= out_src_d;
         err_q         <= err_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_payload = out_payload_q;
   assign out_src     = out_src_q;
   assign credit_err  = err_q;

endmodule

// File: tb/tb_credit_rr_tx.sv
// Directed bench for credit_rr_tx with QUEUE_COUNT=2, DEPTH=4, CNT_WIDTH=3.
module tb_credit_rr_tx;

   localparam int QC    = 2;
   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int CW    = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic [QC-1:0]    in_valid;
   logic [QC-1:0]    in_ready;
   logic [QC*DW-1:0] in_payload;
   logic             out_valid;
   logic             out_ready;
   logic [DW-1:0]    out_payload;
   logic             out_src;
   logic             credit_valid;
   logic [QC*CW-1:0] credit_freed;
   logic             credit_err;

   int checks = 0;
   int errors = 0;

   credit_rr_tx #(
      .QUEUE_COUNT(QC),
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_payload  (in_payload),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_payload (out_payload),
      .out_src     (out_src),
      .credit_valid(credit_valid),
      .credit_freed(credit_freed),
      .credit_err  (credit_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_credit(input logic [CW-1:0] f1, input logic [CW-1:0] f0);
      credit_freed = {f1, f0};
      credit_valid = 1'b1;
      tick();
      credit_valid = 1'b0;
   endtask

   initial begin
      rst          = 1'b1;
      in_valid     = 2'b11;
      in_payload   = '0;
      out_ready    = 1'b0;
      credit_valid = 1'b0;
      credit_freed = '0;
      tick();
      tick();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_payload", 32'(out_payload), 32'd0);
      check("rst_src", 32'(out_src), 32'd0);
      check("rst_err", 32'(credit_err), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);

      // Four beats from q0 on consecutive cycles, then out of credit.
      rst       = 1'b0;
      in_valid  = 2'b01;
      out_ready = 1'b1;
      for (int n = 0; n < 4; n++) begin
         in_payload = {8'h00, DW'(8'hA0 + n)};
         #1;
         check("a_ready", 32'(in_ready), 32'h1);
         tick();
         check("a_valid", 32'(out_valid), 32'd1);
         check("a_payload", 32'(out_payload), 32'(8'hA0 + n));
         check("a_src", 32'(out_src), 32'd0);
      end
      check("a_exhausted", 32'(in_ready), 32'd0);
      tick();
      check("a_drain", 32'(out_valid), 32'd0);
      check("a_still_blocked", 32'(in_ready), 32'd0);
      tick();
      check("a_still_blocked2", 32'(in_ready), 32'd0);

      // Credit return freed0=2: not visible until the next cycle.
      credit_freed = {3'd0, 3'd2};
      credit_valid = 1'b1;
      #1;
      check("b_indep", 32'(in_ready), 32'd0);
      in_valid = 2'b00;
      tick();
      credit_valid = 1'b0;
      check("b_err0", 32'(credit_err), 32'd0);
      in_valid = 2'b01;
      #1;
      check("b_reopen", 32'(in_ready), 32'h1);
      in_valid = 2'b00;
      // Stale freed0=1: delta 7 exceeds inflight 2.
      send_credit(3'd0, 3'd1);
      check("c_err_set", 32'(credit_err), 32'd1);
      in_valid = 2'b01;
      for (int n = 0; n < 2; n++) begin
         in_payload = {8'h00, DW'(8'hB0 + n)};
         #1;
         check("c_ready", 32'(in_ready), 32'h1);
         tick();
         check("c_payload", 32'(out_payload), 32'(8'hB0 + n));
      end
      check("c_limit", 32'(in_ready), 32'd0);
      send_credit(3'd0, 3'd2);
      check("c_err_sticky", 32'(credit_err), 32'd1);
      check("c_dup_noop", 32'(in_ready), 32'd0);

      // Counter wrap: sent0 6->7->0->1->2 against freed0 6 then freed0 2.
      send_credit(3'd0, 3'd6);
      for (int n = 0; n < 4; n++) begin
         in_payload = {8'h00, DW'(8'hC0 + n)};
         #1;
         check("d_ready", 32'(in_ready), 32'h1);
         tick();
         check("d_payload", 32'(out_payload), 32'(8'hC0 + n));
      end
      check("d_wrap_block", 32'(in_ready), 32'd0);
      send_credit(3'd0, 3'd2);
      check("d_wrap_free", 32'(in_ready), 32'h1);
      check("d_err_kept", 32'(credit_err), 32'd1);

      // Both queues valid: rr pointer sits at q1, so q1 goes first.
      in_valid = 2'b11;
      for (int k = 0; k < 6; k++) begin
         in_payload = {DW'(8'h20 + k), DW'(8'h10 + k)};
         #1;
         check("e_ready", 32'(in_ready), (k % 2 == 0) ? 32'h2 : 32'h1);
         tick();
         check("e_valid", 32'(out_valid), 32'd1);
         check("e_src", 32'(out_src), (k % 2 == 0) ? 32'd1 : 32'd0);
         check("e_payload", 32'(out_payload), (k % 2 == 0) ? 32'(8'h20 + k) : 32'(8'h10 + k));
      end

      // Stall with a held beat, then reset mid-stall.
      out_ready  = 1'b0;
      in_payload = {8'hFF, 8'hEE};
      #1;
      check("f_stall_ready", 32'(in_ready), 32'd0);
      for (int s = 0; s < 5; s++) begin
         tick();
         check("f_hold_valid", 32'(out_valid), 32'd1);
         check("f_hold_payload", 32'(out_payload), 32'h15);
         check("f_hold_src", 32'(out_src), 32'd0);
         check("f_hold_ready", 32'(in_ready), 32'd0);
      end
      rst = 1'b1;
      tick();
      check("f_rst_valid", 32'(out_valid), 32'd0);
      check("f_rst_payload", 32'(out_payload), 32'd0);
      check("f_rst_err", 32'(credit_err), 32'd0);
      check("f_rst_ready", 32'(in_ready), 32'd0);
      rst       = 1'b0;
      out_ready = 1'b1;
      in_valid  = 2'b01;
      // Full credit restored; a credit on beat 3 lands together with that send.
      for (int n = 0; n < 5; n++) begin
         in_payload = {8'h00, DW'(8'hE0 + n)};
         if (n == 3) begin
            credit_freed = {3'd0, 3'd1};
            credit_valid = 1'b1;
         end
         #1;
         check("g_ready", 32'(in_ready), 32'h1);
         tick();
         credit_valid = 1'b0;
         check("g_payload", 32'(out_payload), 32'(8'hE0 + n));
         check("g_src", 32'(out_src), 32'd0);
      end
      check("g_block", 32'(in_ready), 32'd0);
      check("g_err", 32'(credit_err), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
